// File: rtl/alu_arb.sv
// alu_arb: two requesters time-share one ALU under round-robin arbitration.
// Results come back through a one-entry registered response with valid/ready.

module alu_arb_alu #(
    parameter int DATA_LEN = 32
) (
    input  logic [3:0]          op,
    input  logic [DATA_LEN-1:0] src1,
    input  logic [DATA_LEN-1:0] src2,
    output logic [DATA_LEN-1:0] result,
    output logic                less,
    output logic                zero
);

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_SLL  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_SLT  = 4'd8;
    localparam logic [3:0] ALU_OP_SLTU = 4'd9;

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       is_cmp;

    assign shamt  = src2[4:0];
    assign lt_s   = $signed(src1) < $signed(src2);
    assign lt_u   = src1 < src2;
    assign is_cmp = (op == ALU_OP_SLT) || (op == ALU_OP_SLTU);

    // Result selection; unknown codes fall through to zero.
    always_comb begin
        result = '0;
        case (op)
            ALU_OP_ADD:  result = src1 + src2;
            ALU_OP_SUB:  result = src1 - src2;
            ALU_OP_AND:  result = src1 & src2;
            ALU_OP_OR:   result = src1 | src2;
            ALU_OP_XOR:  result = src1 ^ src2;
            ALU_OP_SLL:  result = src1 << shamt;
            ALU_OP_SRL:  result = src1 >> shamt;
            ALU_OP_SRA:  result = $signed(src1) >>> shamt;
            ALU_OP_SLT:  result = {{(DATA_LEN-1){1'b0}}, lt_s};
            ALU_OP_SLTU: result = {{(DATA_LEN-1){1'b0}}, lt_u};
            default:     result = '0;
        endcase
    end

    // Compares report their own flag; everything else reports the sign bit.
    always_comb begin
        less = result[DATA_LEN-1];
        if (is_cmp) begin
            less = (op == ALU_OP_SLT) ? lt_s : lt_u;
        end
    end

    assign zero = (result == '0);

endmodule

module alu_arb #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_LEN-1:0] req0_src1,
    input  logic [DATA_LEN-1:0] req0_src2,
    input  logic [3:0]          req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_LEN-1:0] req1_src1,
    input  logic [DATA_LEN-1:0] req1_src2,
    input  logic [3:0]          req1_op,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [DATA_LEN-1:0] resp_result,
    output logic                resp_less,
    output logic                resp_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state;
    logic   rr;
    logic   window;
    logic   grant0;
    logic   grant1;
    logic   accept;
    logic   sel;

    logic [DATA_LEN-1:0] alu_src1;
    logic [DATA_LEN-1:0] alu_src2;
    logic [3:0]          alu_op;
    logic [DATA_LEN-1:0] alu_result;
    logic                alu_less;
    logic                alu_zero;

    // Window opens when nothing is held, or the held response leaves now.
    always_comb begin
        window = 1'b0;
        if (!rst) begin
            window = (state == IDLE) || resp_ready;
        end
    end

    // Round-robin pick; rr only breaks ties when both requesters are valid.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !rr);
        grant1 = req1_valid && (!req0_valid || rr);
    end

    assign req0_ready = window && grant0;
    assign req1_ready = window && grant1;
    assign accept     = req0_ready || req1_ready;
    assign sel        = req1_ready;

    // Steer the granted requester's operands into the shared ALU.
    always_comb begin
        alu_src1 = req0_src1;
        alu_src2 = req0_src2;
        alu_op   = req0_op;
        if (sel) begin
            alu_src1 = req1_src1;
            alu_src2 = req1_src2;
            alu_op   = req1_op;
        end
    end

    alu_arb_alu #(
        .DATA_LEN (DATA_LEN)
    ) u_alu (
        .op     (alu_op),
        .src1   (alu_src1),
        .src2   (alu_src2),
        .result (alu_result),
        .less   (alu_less),
        .zero   (alu_zero)
    );

    // Response FSM: load on accept, drain on handshake, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr          <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_less   <= 1'b0;
            resp_zero   <= 1'b0;
        end else if (accept) begin
            state       <= RESP;
            rr          <= ~sel;
            resp_valid  <= 1'b1;
            resp_id     <= sel;
            resp_result <= alu_result;
            resp_less   <= alu_less;
            resp_zero   <= alu_zero;
        end else if (resp_valid && resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed vectors for alu_arb with a queue-based scoreboard.
// The driver queues expected responses on accept; a monitor checks them.

module tb_alu_arb;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        less;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic [3:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;
    logic [3:0]  req1_op;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_less;
    logic        resp_zero;

    exp_t sbq[$];
    exp_t p0;
    exp_t p1;
    int   checks = 0;
    int   failures = 0;
    int   last_grant;

    always #5 clk = ~clk;

    alu_arb #(
        .DATA_LEN (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_src1   (req0_src1),
        .req0_src2   (req0_src2),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_src1   (req1_src1),
        .req1_src2   (req1_src2),
        .req1_op     (req1_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_less   (resp_less),
        .resp_zero   (resp_zero)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every held response must match the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sbq.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                check("resp_id", {31'd0, resp_id}, {31'd0, sbq[0].id});
                check("resp_result", resp_result, sbq[0].res);
                check("resp_less", {31'd0, resp_less}, {31'd0, sbq[0].less});
                check("resp_zero", {31'd0, resp_zero}, {31'd0, sbq[0].zero});
                if (resp_ready) begin
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // One clock: observe readys mid-cycle, queue accepts, land at posedge+1.
    task automatic step();
        @(negedge clk);
        last_grant = -1;
        if (rst) begin
            check("ready0_in_rst", {31'd0, req0_ready}, 32'd0);
            check("ready1_in_rst", {31'd0, req1_ready}, 32'd0);
        end else begin
            if (req0_ready && req1_ready) begin
                check("both_ready", 32'd1, 32'd0);
            end
            if (req0_valid && req0_ready) begin
                sbq.push_back(p0);
                last_grant = 0;
            end
            if (req1_valid && req1_ready) begin
                sbq.push_back(p1);
                last_grant = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r,
                        input logic l, input logic z);
        req0_op = op;
        req0_src1 = a;
        req0_src2 = b;
        p0 = '{id: 1'b0, res: r, less: l, zero: z};
    endtask

    task automatic set1(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r,
                        input logic l, input logic z);
        req1_op = op;
        req1_src1 = a;
        req1_src2 = b;
        p1 = '{id: 1'b1, res: r, less: l, zero: z};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sbq.delete();
    endtask

    // Single request from one requester, response drained right away.
    task automatic single(input int id);
        resp_ready = 1'b1;
        if (id == 0) req0_valid = 1'b1;
        else req1_valid = 1'b1;
        step();
        check("single_grant", last_grant, id);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        set0(OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        set1(OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        do_reset();
        check("reset_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_result", resp_result, 32'd0);
        check("reset_id", {31'd0, resp_id}, 32'd0);

        // ADD 5+7 with latency and return-to-idle checks.
        resp_ready = 1'b1;
        set0(OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        req0_valid = 1'b1;
        step();
        check("add_grant", last_grant, 0);
        req0_valid = 1'b0;
        check("add_valid_n1", {31'd0, resp_valid}, 32'd1);
        step();
        check("add_idle_n2", {31'd0, resp_valid}, 32'd0);

        // Contention straight after reset: 0,1,0,1 one per cycle.
        do_reset();
        resp_ready = 1'b1;
        set0(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        set1(OP_SUB, 32'd10, 32'd4, 32'd6, 1'b0, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_grant", last_grant, i % 2);
            check("rr_valid", {31'd0, resp_valid}, 32'd1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Backpressure: held SUB 3-3 while req0 waits.
        resp_ready = 1'b1;
        set1(OP_SUB, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        req1_valid = 1'b1;
        step();
        check("bp_grant1", last_grant, 1);
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        set0(OP_ADD, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b1, 1'b0);
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_no_grant", last_grant, -1);
            check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        step();
        check("bp_reopen", last_grant, 0);
        req0_valid = 1'b0;
        step();

        // Compare and assorted ops.
        set0(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0);
        single(0);
        set1(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        single(1);
        set0(OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b1, 1'b0);
        single(0);
        set1(OP_SLL, 32'd1, 32'd33, 32'd2, 1'b0, 1'b0);
        single(1);
        set0(OP_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0);
        single(0);
        set1(OP_XOR, 32'h0000_F0F0, 32'h0000_FFFF, 32'h0000_0F0F, 1'b0, 1'b0);
        single(1);
        set0(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
        single(0);
        set1(4'd15, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1);
        single(1);

        // Reset while a response is held.
        set1(OP_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        step();
        check("pre_rst_grant", last_grant, 1);
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        rst = 1'b1;
        step();
        sbq.delete();
        rst = 1'b0;
        check("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mid_id", {31'd0, resp_id}, 32'd0);
        check("rst_mid_result", resp_result, 32'd0);
        check("rst_mid_less", {31'd0, resp_less}, 32'd0);
        check("rst_mid_zero", {31'd0, resp_zero}, 32'd0);
        resp_ready = 1'b1;
        set0(OP_ADD, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);
        set1(OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        check("post_rst_rr", last_grant, 0);
        req0_valid = 1'b0;
        step();
        check("post_rst_grant1", last_grant, 1);
        req1_valid = 1'b0;
        step();
        step();
        check("drained", sbq.size(), 0);
        check("final_idle", {31'd0, resp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: ysyx_23060025_alu_arb

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, the operand and result width.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have req0_valid  input  1  requester 0 has an operation pending.
REQ-006 SHALL have req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-007 SHALL have req0_src1, req0_src2  input  DATA_LEN  requester 0 operands.
REQ-008 SHALL have req0_op  input  4  requester 0 ALU op code, using the team's ALU_OP_* encoding.
REQ-009 SHALL have req1_valid, req1_ready, req1_src1, req1_src2, req1_op with the same widths and meaning for requester 1.
REQ-010 SHALL have resp_valid  output  1  the response registers hold a result.
REQ-011 SHALL have resp_ready  input  1  the consumer accepts the response.
REQ-012 SHALL have resp_id  output  1  index of the requester that owns the response.
REQ-013 SHALL have resp_result  output  DATA_LEN  registered ALU result.
REQ-014 SHALL have resp_less, resp_zero  output  1 each  registered ALU less and zero flags.

Function
REQ-015 SHALL contain exactly one ALU instance, time-shared between requester 0 and requester 1.
REQ-016 SHALL implement two states: IDLE (no response held) and RESP (response held, resp_valid=1).
REQ-017 SHALL use an arbitration window that is open in IDLE, and in RESP only in a cycle with resp_ready=1.
REQ-018 SHALL grant while the window is open: exactly one valid requester gets the grant; if both are valid, the grant goes to the requester selected by the round-robin pointer rr (0 means req0).
REQ-019 SHALL drive reqN_ready=1 only for the granted requester in an open window, and 0 otherwise; ready SHALL be combinational from the valids, rr and state.
REQ-020 SHALL route the granted requester's src1, src2 and op to the ALU in the accept cycle, then register result, less, zero and the granted id into the response registers at the next edge.
REQ-021 SHALL give a one-cycle latency: a request accepted in cycle N makes resp_valid=1 in cycle N+1.
REQ-022 SHALL, after an accept, set rr to the index that was not granted (strict alternation under contention).
REQ-023 SHALL leave rr unchanged in a cycle with no accept.
REQ-024 SHALL hold resp_valid, resp_id, resp_result, resp_less and resp_zero stable while resp_valid=1 and resp_ready=0.
REQ-025 SHALL transition RESP to IDLE on a response handshake (resp_valid&resp_ready) with no accept in the same cycle; resp_valid then becomes 0 at the next edge.
REQ-026 SHALL stay in RESP on a response handshake that coincides with an accept, loading the new response at the next edge (back-to-back, one result per cycle).
REQ-027 SHALL transition IDLE to RESP on an accept.
REQ-028 SHALL NOT modify the response registers when there is no accept.
REQ-029 SHALL pass an unknown op through to the ALU unmodified, so the response carries result=0 with the corresponding flags.
REQ-030 SHALL keep resp_result, resp_less and resp_zero bit-exact with the ALU for the latched operands: shift amounts are src2[4:0], and less is the signed/unsigned compare flag for SLT/SLTU ops and result[31] otherwise.
REQ-031 SHALL ignore a requester deasserting valid before ready (no accept, no state change); requesters keep operands stable while valid and not ready.

Reset
REQ-032 SHALL, while rst=1 at an edge, enter IDLE and clear resp_valid, resp_id, resp_result, resp_less, resp_zero and rr to 0.
REQ-033 SHALL drive both reqN_ready=0 in any cycle with rst=1.
REQ-034 SHALL discard a request accepted or a response pending when rst rises, with no response produced for it.

Verification
REQ-035 SHALL cover a single request: req0 valid with ADD 5+7 and resp_ready=1 -> req0_ready=1 in cycle N; resp_valid=1, resp_id=0, resp_result=12 and resp_zero=0 in cycle N+1; IDLE in N+2.
REQ-036 SHALL cover contention: both valid continuously and resp_ready=1 after reset -> grants alternate 0,1,0,1, with one response per cycle.
REQ-037 SHALL cover backpressure: req1 SUB 3-3 accepted and resp_ready=0 for 4 cycles -> response holds resp_zero=1, resp_result=0, resp_id=1; both readys stay 0; the window reopens when resp_ready=1.
REQ-038 SHALL cover compare ops: SLT with 0xFFFFFFFF vs 1 -> result=1 and less=1; SLTU with the same operands -> result=0 and less=0.
REQ-039 SHALL cover reset mid-operation: rst=1 while in RESP -> the next cycle shows resp_valid=0, rr=0 and all outputs 0; a subsequent request completes normally.
